stream_spill_fifo: RTL and testbench
====================================

// Module: stream_spill_fifo
// PURPOSE
// Parametrised single-clock elastic buffer for valid/ready streams. Depth configurable,
// fill level exported, synchronous flush provided. Cuts every combinational path
// src->dst and dst->src: ready/valid are functions of registered state only
// (plus reset/flush gating). Placed between pipeline stages or at IP boundaries
// where timing isolation and several entries of slack are both needed.
// PARAMETERS
// DataWidth  32  payload width in bits (>=1)
// Depth      2   number of storage entries (>=1, need not be a power of two)
// Bypass     0   1: pure wire, no storage, no registers
// PORTS
// clk_i        in   1                   clock, all state on rising edge
// rst_i        in   1                   synchronous reset, active-high
// flush_i      in   1                   synchronous clear of all stored entries
// src_valid_i  in   1                   upstream data valid
// src_ready_o  out  1                   buffer can accept a word
// src_data_i   in   DataWidth           upstream payload
// dst_valid_o  out  1                   buffer holds a word for downstream
// dst_ready_i  in   1                   downstream accepts
// dst_data_o   out  DataWidth           head-of-buffer payload
// usage_o      out  $clog2(Depth+1)     number of stored entries, 0..Depth
// BEHAVIOUR
// - State: wr_ptr, rd_ptr in 0..Depth-1 (wrap Depth-1 -> 0, explicit compare, no
//   power-of-two masking); count in 0..Depth; mem[Depth] (no reset on mem).
// - push = src_valid_i & src_ready_o; pop = dst_valid_o & dst_ready_i.
// - src_ready_o = (count != Depth) & ~rst_i & ~flush_i.
// - dst_valid_o = (count != 0) & ~rst_i & ~flush_i; dst_data_o = mem[rd_ptr].
// - push: mem[wr_ptr] <= src_data_i, wr_ptr advances. pop: rd_ptr advances.
// - count_next = count + push - pop; push&pop together leaves count unchanged.
// - Full (count==Depth): src_ready_o=0 even if pop occurs the same cycle; the
//   freed slot is offered the following cycle (no dst->src comb path).
// - Empty (count==0): dst_valid_o=0 even if push occurs the same cycle; no
//   fall-through. Min latency push->dst_valid_o = 1 cycle.
// - Order strictly FIFO across wrap-around. dst_data_o is don't-care when
//   dst_valid_o=0; it is stable while dst_valid_o=1 and no pop occurs.
// - Once dst_valid_o=1, it stays 1 with unchanged data until pop (AXI-style),
//   except on rst_i or flush_i.
// - rst_i=1 at an edge: wr_ptr=rd_ptr=0, count=0. While rst_i=1:
//   src_ready_o=0, dst_valid_o=0, usage_o=registered count. First cycle after
//   release: src_ready_o=1, dst_valid_o=0, usage_o=0. Reset mid-transfer drops
//   all stored words; no handshake completes in a reset cycle.
// - flush_i=1: same clearing as rst_i at the next edge; src_ready_o and
//   dst_valid_o forced 0 in the flush cycle, so no push/pop completes. rst_i has
//   priority (identical effect). usage_o=0 the cycle after flush.
// - usage_o = count (registered, no comb input dependence).
// - Bypass=1: dst_valid_o=src_valid_i, src_ready_o=dst_ready_i,
//   dst_data_o=src_data_i, usage_o=0; clk_i/rst_i/flush_i unused.
// TESTING
// 1 Reset: rst_i=1 two cycles with src_valid_i=1 -> src_ready_o=0, dst_valid_o=0,
//   usage_o=0; release -> src_ready_o=1 next cycle, nothing stored.
// 2 Fill/drain Depth=4: push 0xA0..0xA3, dst_ready_i=0 -> usage_o 1,2,3,4, then
//   src_ready_o=0; dst_ready_i=1 -> dst_data_o A0,A1,A2,A3 on consecutive cycles.
// 3 Full+simultaneous Depth=4: full, src_valid_i=1,dst_ready_i=1 -> pop only,
//   usage_o=3; next cycle push and pop both accepted, usage_o stays 3.
// 4 Wrap Depth=3: 10 words 0x01..0x0A, continuous valid/ready -> out 0x01..0x0A in
//   order, usage_o steady at 1, first dst_valid_o one cycle after first push.
// 5 Flush Depth=4: 3 stored, flush_i=1 with src_valid_i=1 data 0x55 -> ready/valid
//   0 that cycle; next cycle usage_o=0, dst_valid_o=0; 0x55 never emitted.
// 6 Bypass=1: src_data_i=0x1234,valid=1,dst_ready_i=0 -> dst_data_o=0x1234,
//   dst_valid_o=1, src_ready_o=0 same cycle; usage_o=0.

Source files
------------

// File: rtl/stream_spill_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_spill_fifo_if
// Purpose  : One valid/ready stream link carrying a DATA_WIDTH payload.
//            master : drives valid/data, receives ready
//            slave  : receives valid/data, drives ready
// Revision : 1.0  initial release
// ============================================================================
interface stream_spill_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface : stream_spill_fifo_if
`default_nettype wire

// File: rtl/stream_spill_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stream_spill_fifo
// Purpose  : Single-clock elastic buffer for valid/ready streams. Ready and
//            valid depend only on registered state (plus reset/flush gating),
//            so every src<->dst combinational path is cut.
// Ports    : clk_i    clock, all state on rising edge
//            rst_i    synchronous reset, active-high
//            flush_i  synchronous clear of all stored entries
//            src      slave stream (upstream producer)
//            dst      master stream (downstream consumer)
//            usage_o  number of stored entries, 0..DEPTH (registered)
// Revision : 1.0  initial release
// ============================================================================
module stream_spill_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter bit BYPASS     = 1'b0
) (
  input  wire logic                       clk_i,
  input  wire logic                       rst_i,
  input  wire logic                       flush_i,
  stream_spill_fifo_if.slave              src,
  stream_spill_fifo_if.master             dst,
  output logic [$clog2(DEPTH+1)-1:0]      usage_o
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (BYPASS) begin : g_bypass
      // Pure wire: no storage, clock/reset/flush intentionally ignored.
      logic w_unused;
      assign w_unused  = ^{clk_i, rst_i, flush_i};
      assign dst.valid = src.valid;
      assign dst.data  = src.data;
      assign src.ready = dst.ready;
      assign usage_o   = '0;
    end else begin : g_fifo
      localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
      localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(DEPTH);

      logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      logic [c_ptr_w-1:0]    r_wr_ptr;
      logic [c_ptr_w-1:0]    r_rd_ptr;
      logic [c_cnt_w-1:0]    r_count;
      logic                  w_src_ready;
      logic                  w_dst_valid;
      logic                  w_push;
      logic                  w_pop;

      // Gating with rst_i/flush_i guarantees no handshake completes in a
      // clearing cycle, so the clear below never races a push or pop.
      assign w_src_ready = (r_count != c_full) & ~rst_i & ~flush_i;
      assign w_dst_valid = (r_count != '0)     & ~rst_i & ~flush_i;
      assign w_push      = src.valid & w_src_ready;
      assign w_pop       = w_dst_valid & dst.ready;

      assign src.ready = w_src_ready;
      assign dst.valid = w_dst_valid;
      assign dst.data  = r_mem[r_rd_ptr];
      assign usage_o   = r_count;

      always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          // Explicit wrap compare so non-power-of-two depths work.
          if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_w'(1);
          end
          if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_w'(1);
          end
          case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
          endcase
        end
      end

      // Storage carries no reset; contents are only visible behind valid.
      always_ff @(posedge clk_i) begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= src.data;
        end
      end
    end
  endgenerate

endmodule : stream_spill_fifo
`default_nettype wire

// File: tb/tb_stream_spill_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_spill_fifo
// Purpose  : Directed self-checking bench for stream_spill_fifo. Three
//            instances: DEPTH=4 (a), DEPTH=3 (b), BYPASS=1 (c).
// Revision : 1.0  initial release
// ============================================================================
module tb_stream_spill_fifo;

  logic clk = 1'b0;
  logic rst;
  logic flush_a, flush_b, flush_c;
  logic [2:0] usage_a;
  logic [1:0] usage_b;
  logic [1:0] usage_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_spill_fifo_if #(.DATA_WIDTH(16)) src_a ();
  stream_spill_fifo_if #(.DATA_WIDTH(16)) dst_a ();
  stream_spill_fifo_if #(.DATA_WIDTH(16)) src_b ();
  stream_spill_fifo_if #(.DATA_WIDTH(16)) dst_b ();
  stream_spill_fifo_if #(.DATA_WIDTH(16)) src_c ();
  stream_spill_fifo_if #(.DATA_WIDTH(16)) dst_c ();

  stream_spill_fifo #(.DATA_WIDTH(16), .DEPTH(4), .BYPASS(1'b0)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .src(src_a), .dst(dst_a), .usage_o(usage_a));
  stream_spill_fifo #(.DATA_WIDTH(16), .DEPTH(3), .BYPASS(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_b), .src(src_b), .dst(dst_b), .usage_o(usage_b));
  stream_spill_fifo #(.DATA_WIDTH(16), .DEPTH(2), .BYPASS(1'b1)) u_c (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_c), .src(src_c), .dst(dst_c), .usage_o(usage_c));

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_a.valid = 1'b1; src_a.data = 16'hBEEF; dst_a.ready = 1'b0;
    #1;
    n_checks++; if (src_a.ready !== 1'b0) begin n_fail++; $display("FAIL reset_src_ready: got %b want 0", src_a.ready); end
    n_checks++; if (dst_a.valid !== 1'b0) begin n_fail++; $display("FAIL reset_dst_valid: got %b want 0", dst_a.valid); end
    tick();
    tick();
    n_checks++; if (usage_a !== 3'd0) begin n_fail++; $display("FAIL reset_usage: got %0d want 0", usage_a); end
    n_checks++; if (src_a.ready !== 1'b0) begin n_fail++; $display("FAIL reset_src_ready2: got %b want 0", src_a.ready); end
    rst = 1'b0;
    src_a.valid = 1'b0;
    #1;
    n_checks++; if (src_a.ready !== 1'b1) begin n_fail++; $display("FAIL release_src_ready: got %b want 1", src_a.ready); end
    n_checks++; if (dst_a.valid !== 1'b0) begin n_fail++; $display("FAIL release_dst_valid: got %b want 0", dst_a.valid); end
    n_checks++; if (usage_b !== 2'd0) begin n_fail++; $display("FAIL release_usage_b: got %0d want 0", usage_b); end
    tick();
    n_checks++; if (usage_a !== 3'd0) begin n_fail++; $display("FAIL release_usage: got %0d want 0", usage_a); end
  endtask

  task automatic test_fill_drain();
    dst_a.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src_a.valid = 1'b1; src_a.data = 16'(16'hA0 + i);
      #1;
      n_checks++; if (src_a.ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b want 1", i, src_a.ready); end
      tick();
      n_checks++; if (usage_a !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_usage[%0d]: got %0d want %0d", i, usage_a, i + 1); end
    end
    src_a.data = 16'hEE;
    #1;
    n_checks++; if (src_a.ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", src_a.ready); end
    src_a.valid = 1'b0; dst_a.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (dst_a.valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want 1", i, dst_a.valid); end
      n_checks++; if (dst_a.data !== 16'(16'hA0 + i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, dst_a.data, 16'hA0 + i); end
      tick();
    end
    #1;
    n_checks++; if (dst_a.valid !== 1'b0) begin n_fail++; $display("FAIL drained_valid: got %b want 0", dst_a.valid); end
    n_checks++; if (usage_a !== 3'd0) begin n_fail++; $display("FAIL drained_usage: got %0d want 0", usage_a); end
    dst_a.ready = 1'b0;
  endtask

  task automatic test_full_simultaneous();
    logic [15:0] exp_q [3];
    dst_a.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src_a.valid = 1'b1; src_a.data = 16'(16'hB0 + i);
      tick();
    end
    n_checks++; if (usage_a !== 3'd4) begin n_fail++; $display("FAIL simul_full_usage: got %0d want 4", usage_a); end
    src_a.valid = 1'b1; src_a.data = 16'hB4; dst_a.ready = 1'b1;
    #1;
    n_checks++; if (src_a.ready !== 1'b0) begin n_fail++; $display("FAIL simul_full_ready: got %b want 0", src_a.ready); end
    n_checks++; if (dst_a.data !== 16'hB0) begin n_fail++; $display("FAIL simul_head: got %h want b0", dst_a.data); end
    tick();
    n_checks++; if (usage_a !== 3'd3) begin n_fail++; $display("FAIL simul_pop_only_usage: got %0d want 3", usage_a); end
    n_checks++; if (src_a.ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready_after: got %b want 1", src_a.ready); end
    n_checks++; if (dst_a.data !== 16'hB1) begin n_fail++; $display("FAIL simul_head2: got %h want b1", dst_a.data); end
    tick();
    n_checks++; if (usage_a !== 3'd3) begin n_fail++; $display("FAIL simul_both_usage: got %0d want 3", usage_a); end
    src_a.valid = 1'b0;
    exp_q = '{16'hB2, 16'hB3, 16'hB4};
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (dst_a.valid !== 1'b1 || dst_a.data !== exp_q[i]) begin n_fail++; $display("FAIL simul_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, dst_a.valid, dst_a.data, exp_q[i]); end
      tick();
    end
    n_checks++; if (usage_a !== 3'd0) begin n_fail++; $display("FAIL simul_end_usage: got %0d want 0", usage_a); end
    dst_a.ready = 1'b0;
  endtask

  task automatic test_wrap();
    dst_b.ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      src_b.valid = (k < 10); src_b.data = 16'(k + 1);
      #1;
      if (k == 0) begin
        n_checks++; if (dst_b.valid !== 1'b0) begin n_fail++; $display("FAIL wrap_no_fallthrough: got %b want 0", dst_b.valid); end
      end else begin
        n_checks++; if (dst_b.valid !== 1'b1 || dst_b.data !== 16'(k)) begin n_fail++; $display("FAIL wrap_out[%0d]: got v=%b d=%h want v=1 d=%h", k, dst_b.valid, dst_b.data, k); end
        n_checks++; if (usage_b !== 2'd1) begin n_fail++; $display("FAIL wrap_usage[%0d]: got %0d want 1", k, usage_b); end
      end
      tick();
    end
    n_checks++; if (usage_b !== 2'd0 || dst_b.valid !== 1'b0) begin n_fail++; $display("FAIL wrap_end: got u=%0d v=%b want u=0 v=0", usage_b, dst_b.valid); end
    src_b.valid = 1'b0; dst_b.ready = 1'b0;
  endtask

  task automatic test_flush();
    dst_a.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      src_a.valid = 1'b1; src_a.data = 16'(16'hC0 + i);
      tick();
    end
    n_checks++; if (usage_a !== 3'd3) begin n_fail++; $display("FAIL flush_pre_usage: got %0d want 3", usage_a); end
    flush_a = 1'b1; src_a.valid = 1'b1; src_a.data = 16'h55; dst_a.ready = 1'b1;
    #1;
    n_checks++; if (src_a.ready !== 1'b0) begin n_fail++; $display("FAIL flush_src_ready: got %b want 0", src_a.ready); end
    n_checks++; if (dst_a.valid !== 1'b0) begin n_fail++; $display("FAIL flush_dst_valid: got %b want 0", dst_a.valid); end
    tick();
    flush_a = 1'b0; src_a.valid = 1'b0;
    #1;
    n_checks++; if (usage_a !== 3'd0) begin n_fail++; $display("FAIL flush_usage: got %0d want 0", usage_a); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (dst_a.valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak[%0d]: got v=%b d=%h want v=0", i, dst_a.valid, dst_a.data); end
      tick();
    end
    src_a.valid = 1'b1; src_a.data = 16'h66;
    tick();
    src_a.valid = 1'b0;
    #1;
    n_checks++; if (dst_a.valid !== 1'b1 || dst_a.data !== 16'h66) begin n_fail++; $display("FAIL flush_recover: got v=%b d=%h want v=1 d=0066", dst_a.valid, dst_a.data); end
    tick();
    dst_a.ready = 1'b0;
  endtask

  task automatic test_bypass();
    src_c.valid = 1'b1; src_c.data = 16'h1234; dst_c.ready = 1'b0;
    #1;
    n_checks++; if (dst_c.data !== 16'h1234) begin n_fail++; $display("FAIL bypass_data: got %h want 1234", dst_c.data); end
    n_checks++; if (dst_c.valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid: got %b want 1", dst_c.valid); end
    n_checks++; if (src_c.ready !== 1'b0) begin n_fail++; $display("FAIL bypass_ready0: got %b want 0", src_c.ready); end
    n_checks++; if (usage_c !== 2'd0) begin n_fail++; $display("FAIL bypass_usage: got %0d want 0", usage_c); end
    dst_c.ready = 1'b1; src_c.valid = 1'b0;
    #1;
    n_checks++; if (src_c.ready !== 1'b1 || dst_c.valid !== 1'b0) begin n_fail++; $display("FAIL bypass_follow: got r=%b v=%b want r=1 v=0", src_c.ready, dst_c.valid); end
  endtask

  initial begin
    rst = 1'b1; flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
    src_a.valid = 1'b0; src_a.data = '0; dst_a.ready = 1'b0;
    src_b.valid = 1'b0; src_b.data = '0; dst_b.ready = 1'b0;
    src_c.valid = 1'b0; src_c.data = '0; dst_c.ready = 1'b0;
    tick();
    test_reset();
    test_fill_drain();
    test_full_simultaneous();
    test_wrap();
    test_flush();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_stream_spill_fifo
`default_nettype wire
